des_key_sched: RTL and testbench
================================

DES_KEY_SCHED -- requirements
Module: des_key_sched

Interface
REQ-001 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 Port rst, input, 1: reset is synchronous and active-high.
REQ-003 Port key_in, input, 64: DES key; bit 1 (FIPS numbering) = key_in[63]; sampled only on an accepted start.
REQ-004 Port decrypt, input, 1: 0 = encrypt order (K1..K16), 1 = decrypt order (K16..K1); sampled with key_in.
REQ-005 Port start, input, 1: request a 16-round key sequence; accepted only in IDLE.
REQ-006 Port busy, output, 1: high in LOAD, ROUND and DONE.
REQ-007 Port round, output, 5: round counter for the Feistel datapath (0 = load L0/R0, 1..16 = rounds, 17 = last-valid); 5'd31 when idle.
REQ-008 Port subkey, output, 48: PC-2 output for the current round.
REQ-009 Port subkey_valid, output, 1: high exactly while round is 1..16.
REQ-010 Port done, output, 1: one-cycle pulse coincident with round == 17.
REQ-011 Port key_err, output, 1: one-cycle parity-reject pulse; exists in both builds.

Function
REQ-012 FSM states IDLE, LOAD, ROUND, DONE; IDLE -> LOAD on start; LOAD -> ROUND; ROUND -> DONE after round 16; DONE -> IDLE.
REQ-013 Start accepted at edge T: cycle after T is LOAD with round = 0; the next 16 cycles are ROUND with round = 1..16; the following cycle is DONE with round = 17 and done = 1; then IDLE.
REQ-014 LOAD applies PC-1 to the latched key to produce C0 and D0 (28 bits each); subkey = 0 and subkey_valid = 0 in LOAD.
REQ-015 Encrypt: round i rotates C and D left by s_i (s_i = 1 for i = 1, 2, 9, 16, else 2) and outputs subkey = PC-2(C_i, D_i) in the same cycle round = i.
REQ-016 Decrypt: round 1 outputs PC-2(C0, D0) with no rotation; round i > 1 rotates C and D right by s_(18-i) before applying PC-2, yielding K(17-i).
REQ-017 PC-1 and PC-2 tables and shift schedule exactly per FIPS 46-3; the eight parity bits are discarded by PC-1.
REQ-018 start while busy is ignored and does not alter key, direction or sequence.
REQ-019 start in the DONE cycle is ignored; a new start is accepted at the earliest in the following IDLE cycle.
REQ-020 subkey holds its last value in DONE and is driven to 0 in IDLE.
REQ-021 key_in and decrypt changes after acceptance have no effect on the running sequence.

Reset
REQ-022 rst at any clock edge, including mid-sequence, forces IDLE on that edge; busy = 0, round = 5'd31, subkey = 0, subkey_valid = 0, done = 0, key_err = 0, C/D registers = 0.
REQ-023 start asserted in the same cycle as rst is ignored.

Configuration
REQ-024 Macro DES_KEY_PARITY_CHK_EN: when defined, each of the eight key_in bytes is checked for odd parity on start in IDLE; any failing byte rejects the start, pulses key_err for one cycle, and the FSM remains in IDLE.
REQ-025 When DES_KEY_PARITY_CHK_EN is undefined, parity bits are ignored, every start in IDLE is accepted, and key_err is tied to 0.

Verification
REQ-026 key_in = 64'h133457799BBCDFF1, decrypt = 0, start pulse -> round 0 then 1..16; round 1 subkey = 48'h1B02EFFC7072, round 16 subkey = 48'hCB3D8B0E17F5; done with round = 17, 18 cycles after start.
REQ-027 Same key, decrypt = 1 -> round 1 subkey = 48'hCB3D8B0E17F5, round 16 subkey = 48'h1B02EFFC7072; full decrypt sequence equals the encrypt sequence reversed.
REQ-028 start re-pulsed at round = 5 with a different key -> ignored; the sequence completes with the original subkeys.
REQ-029 rst asserted at round = 9 -> next cycle busy = 0, round = 31, subkey = 0; a fresh start then yields the full sequence from round 0.
REQ-030 With DES_KEY_PARITY_CHK_EN, key_in = 64'h0, start -> key_err = 1 for one cycle, busy stays 0; without the macro the same stimulus runs 16 rounds with key_err = 0.
REQ-031 Back-to-back: start held high continuously -> sequences separated by exactly one IDLE cycle, done pulses 19 cycles apart.

Source files
------------

// File: rtl/des_key_sched.sv
// DES key schedule: one 48-bit subkey per cycle over 16 rounds, encrypt or decrypt order; start is ignored while busy.
// Defining DES_KEY_PARITY_CHK_EN rejects keys with an even-parity byte and pulses key_err.
module des_key_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    input  logic        start,
    output logic        busy,
    output logic [4:0]  round,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    output logic        done,
    output logic        key_err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_DONE} state_t;

    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state_q, state_d;
    logic [4:0]  round_q, round_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic        dec_q, dec_d;
    logic        parity_ok;

    // Table bit n (1-based, MSB first) maps to vector index WIDTH-n.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        o = '0;
        for (int i = 0; i < 56; i++) o[55-i] = k[64-PC1_TBL[i]];
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2_TBL[i]];
        return o;
    endfunction

    function automatic logic [27:0] rot(input logic [27:0] v, input logic right, input logic one);
        logic [27:0] o;
        if (!right) o = one ? {v[26:0], v[27]}    : {v[25:0], v[27:26]};
        else        o = one ? {v[0],    v[27:1]}  : {v[1:0],  v[27:2]};
        return o;
    endfunction

    // Decrypt walks the schedule backwards: the shift undone at round r is s(18-r),
    // which is single exactly when r is 2, 9 or 16 -- the same set as encrypt minus round 1.
    function automatic logic [55:0] step(input logic [27:0] c, input logic [27:0] d,
                                         input logic dec, input logic [4:0] r);
        logic one;
        one = (r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16);
        if (dec && r == 5'd1) return {c, d};
        return {rot(c, dec, one), rot(d, dec, one)};
    endfunction

`ifdef DES_KEY_PARITY_CHK_EN
    logic key_err_q, key_err_d;

    always_comb begin
        parity_ok = 1'b1;
        for (int b = 0; b < 8; b++) parity_ok = parity_ok & (^key_in[8*b +: 8]);
    end

    always_comb begin
        key_err_d = 1'b0;
        if (state_q == S_IDLE && start && !parity_ok) key_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) key_err_q <= 1'b0;
        else     key_err_q <= key_err_d;
    end

    assign key_err = key_err_q;
`else
    logic unused_parity_bits;

    assign unused_parity_bits = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                                  key_in[24], key_in[16], key_in[8],  key_in[0]};
    assign parity_ok = 1'b1;
    assign key_err   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        c_d     = c_q;
        d_d     = d_q;
        dec_d   = dec_q;
        case (state_q)
            S_IDLE: begin
                round_d = 5'd31;
                if (start && parity_ok) begin
                    state_d    = S_LOAD;
                    round_d    = 5'd0;
                    {c_d, d_d} = pc1(key_in);
                    dec_d      = decrypt;
                end
            end
            S_LOAD: begin
                state_d    = S_ROUND;
                round_d    = 5'd1;
                {c_d, d_d} = step(c_q, d_q, dec_q, 5'd1);
            end
            S_ROUND: begin
                if (round_q == 5'd16) begin
                    state_d = S_DONE;
                    round_d = 5'd17;
                end else begin
                    round_d    = round_q + 5'd1;
                    {c_d, d_d} = step(c_q, d_q, dec_q, round_q + 5'd1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                round_d = 5'd31;
                c_d     = '0;
                d_d     = '0;
            end
            default: begin
                state_d = S_IDLE;
                round_d = 5'd31;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            round_q <= 5'd31;
            c_q     <= '0;
            d_q     <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            c_q     <= c_d;
            d_q     <= d_d;
            dec_q   <= dec_d;
        end
    end

    // C/D are frozen in DONE, so the final subkey stays visible there.
    assign busy         = (state_q != S_IDLE);
    assign round        = round_q;
    assign subkey_valid = (state_q == S_ROUND);
    assign done         = (state_q == S_DONE);
    assign subkey       = (state_q == S_ROUND || state_q == S_DONE) ? pc2({c_q, d_q}) : 48'h0;

endmodule

// File: tb/tb_des_key_sched.sv
// Scoreboard bench for des_key_sched using the FIPS worked-example key.
module tb_des_key_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] key_in;
    logic        decrypt;
    logic        start;
    logic        busy;
    logic [4:0]  round;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        done;
    logic        key_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct packed {
        logic [4:0]  rnd;
        logic [47:0] sk;
    } exp_t;

    exp_t        expq[$];
    logic [47:0] last_sk = 48'h0;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;

    localparam logic [47:0] KS [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    always #5 clk = ~clk;

    des_key_sched dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .decrypt      (decrypt),
        .start        (start),
        .busy         (busy),
        .round        (round),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .done         (done),
        .key_err      (key_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_seq(input logic dec, input logic zero_key);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.rnd = 5'(i + 1);
            e.sk  = zero_key ? 48'h0 : (dec ? KS[15-i] : KS[i]);
            expq.push_back(e);
        end
    endtask

    task automatic wait_round(input logic [4:0] target);
        int n;
        n = 0;
        while (round !== target && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL wait_round: round %0d never reached, still %0d", target, round);
        end
    endtask

    task automatic wait_done(input int t0);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("done_latency", 64'(cyc - t0), 64'd18);
        check("done_round", round, 5'd17);
        tick();
        check("post_done_busy", busy, 1'b0);
    endtask

    // Issues a one-cycle start and checks the LOAD cycle; returns the cycle count before the start edge.
    task automatic launch(input logic [63:0] key, input logic dec, output int t0);
        key_in  = key;
        decrypt = dec;
        start   = 1'b1;
        t0      = cyc;
        tick();
        start   = 1'b0;
        check("load_busy", busy, 1'b1);
        check("load_round", round, 5'd0);
        check("load_valid", subkey_valid, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (subkey_valid === 1'b1) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_subkey: round %0d subkey %h with nothing expected", round, subkey);
                end else begin
                    e = expq.pop_front();
                    check("round_num", round, e.rnd);
                    check("subkey", subkey, e.sk);
                    last_sk = e.sk;
                end
            end else if (done === 1'b1) begin
                check("done_subkey_hold", subkey, last_sk);
            end else if (busy === 1'b1) begin
                check("load_subkey", subkey, 48'h0);
            end else begin
                check("idle_round", round, 5'd31);
                check("idle_subkey", subkey, 48'h0);
                check("idle_done", done, 1'b0);
            end
`ifndef DES_KEY_PARITY_CHK_EN
            check("key_err_tied", key_err, 1'b0);
`endif
        end
    end

    initial begin : stim
        int t0;
        int d1;
        int d2;
        int ndone;
        int idle_gap;
        rst     = 1'b1;
        start   = 1'b1;
        key_in  = KEY_A;
        decrypt = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_round", round, 5'd31);
        check("rst_subkey", subkey, 48'h0);
        check("rst_valid", subkey_valid, 1'b0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("start_during_rst_ignored", busy, 1'b0);

        // Encrypt, then decrypt of the same key.
        push_seq(1'b0, 1'b0);
        launch(KEY_A, 1'b0, t0);
        wait_done(t0);
        push_seq(1'b1, 1'b0);
        launch(KEY_A, 1'b1, t0);
        wait_done(t0);

        // Restart attempt with a different key and direction mid-sequence.
        push_seq(1'b0, 1'b0);
        launch(KEY_A, 1'b0, t0);
        wait_round(5'd5);
        key_in  = KEY_B;
        decrypt = 1'b1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        wait_done(t0);

        // Reset in the middle, then a clean rerun.
        push_seq(1'b0, 1'b0);
        launch(KEY_A, 1'b0, t0);
        wait_round(5'd9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_round", round, 5'd31);
        check("midrst_subkey", subkey, 48'h0);
        check("midrst_leftover", 64'(expq.size()), 64'd7);
        expq.delete();
        tick();
        push_seq(1'b0, 1'b0);
        launch(KEY_A, 1'b0, t0);
        wait_done(t0);

        // All-zero key: every byte has even parity.
`ifdef DES_KEY_PARITY_CHK_EN
        key_in = 64'h0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("parity_key_err", key_err, 1'b1);
        check("parity_busy", busy, 1'b0);
        tick();
        check("parity_key_err_pulse", key_err, 1'b0);
        check("parity_busy_after", busy, 1'b0);
`else
        push_seq(1'b0, 1'b1);
        launch(64'h0, 1'b0, t0);
        check("zero_key_err", key_err, 1'b0);
        wait_done(t0);
`endif

        // Start held high: two back-to-back sequences.
        push_seq(1'b0, 1'b0);
        push_seq(1'b0, 1'b0);
        key_in   = KEY_A;
        decrypt  = 1'b0;
        start    = 1'b1;
        ndone    = 0;
        d1       = 0;
        d2       = 0;
        idle_gap = 0;
        for (int k = 0; k < 60 && ndone < 2; k++) begin
            tick();
            if (done === 1'b1) begin
                if (ndone == 0) d1 = cyc;
                else            d2 = cyc;
                ndone++;
            end else if (ndone == 1 && busy === 1'b0) begin
                idle_gap++;
            end
        end
        start = 1'b0;
        check("b2b_done_count", 64'(ndone), 64'd2);
        check("b2b_done_spacing", 64'(d2 - d1), 64'd19);
        check("b2b_idle_gap", 64'(idle_gap), 64'd1);
        repeat (3) tick();
        check("b2b_stopped", busy, 1'b0);
        check("queue_drained", 64'(expq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
